// File: rtl/mem_io_arbiter_pkg.sv
// Shared definitions for the memory/IO data-port arbiter.
//   - state_e        : sequencer states
//   - GNT_CPU/LOADER : grant id encoding (also the index of the req bit)
//   - IO window      : default base address and window width
package mem_io_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  localparam logic GNT_CPU    = 1'b0;
  localparam logic GNT_LOADER = 1'b1;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFFFC00;
  localparam int unsigned IO_WIN_W        = 10;

  // Compare only the bits above the IO window.
  function automatic logic is_io_hit(input logic [31-IO_WIN_W:0] addr_hi,
                                     input logic [31-IO_WIN_W:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/mem_io_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   i_req[1:0]    request vector (bit 0 = CPU, bit 1 = loader)
//   i_last_grant  id of the requester served most recently
//   o_gnt[1:0]    one-hot grant (zero when nobody requests)
module mem_io_arbiter_rr_arb2
  import mem_io_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // Tie: serve whoever did not win last time.
      2'b11:   o_gnt = (i_last_grant == GNT_LOADER) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_io_arbiter.sv
// Sequencer/arbiter for the shared data-side port (CPU LSU + UART loader) in front of a
// synchronous RAM (1-cycle read latency) and the memory-mapped IO decoder.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_cpu_* / i_ld_*            req/we/addr/wdata of the two requesters
//   o_cpu_ack / o_ld_ack        one-cycle completion pulses
//   o_cpu_stall                 cpu_req & ~cpu_ack
//   o_rsp_rdata / o_rsp_err     response, valid in the ack cycle
//   o_mem_* / i_mem_rdata       RAM port (word address = addr[ADDR_W+1:2])
//   o_io_* / i_io_rdata         IO decoder port (io_rdata combinational while io_en)
// Build option: define MISALIGN_CHECK_EN to answer accesses with addr[1:0] != 0 with an
// error ack and no strobe; otherwise addr[1:0] is ignored and rsp_err stays 0.
module mem_io_arbiter
  import mem_io_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_stall,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [31:0]       i_ld_addr,
  input  logic [31:0]       i_ld_wdata,
  output logic              o_ld_ack,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_io_en,
  output logic              o_io_we,
  output logic [7:0]        o_io_addr,
  output logic [31:0]       o_io_wdata,
  input  logic [31:0]       i_io_rdata
);

  logic [1:0]  w_gnt;
  logic        w_sel_ld;
  logic        w_we;
  logic        w_io_hit;
  logic        w_misalign;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  state_e              r_state;
  logic                r_last_grant;
  logic                r_gnt;
  logic                r_we;
  logic                r_io;
  logic                r_cpu_ack;
  logic                r_ld_ack;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_io_en;
  logic                r_io_we;
  logic [7:0]          r_io_addr;
  logic [31:0]         r_io_wdata;

  mem_io_arbiter_rr_arb2 u_rr_arb2 (
    .i_req        ({i_ld_req, i_cpu_req}),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  // Grant bit 1 is the loader, matching the GNT_LOADER encoding.
  assign w_sel_ld = w_gnt[1];
  assign w_we     = w_sel_ld ? i_ld_we    : i_cpu_we;
  assign w_addr   = w_sel_ld ? i_ld_addr  : i_cpu_addr;
  assign w_wdata  = w_sel_ld ? i_ld_wdata : i_cpu_wdata;
  assign w_io_hit = is_io_hit(w_addr[31:IO_WIN_W], IO_BASE[31:IO_WIN_W]);

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = (w_addr[1:0] != 2'b00);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^w_addr[1:0];
  assign w_misalign   = 1'b0;
`endif

  // Strobes are registered on the IDLE->ISSUE edge so they are high exactly in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= GNT_LOADER;
      r_gnt        <= GNT_CPU;
      r_we         <= 1'b0;
      r_io         <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_ld_ack     <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_io_en      <= 1'b0;
      r_io_we      <= 1'b0;
      r_io_addr    <= '0;
      r_io_wdata   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_gnt != 2'b00) begin
            r_gnt   <= w_sel_ld;
            r_we    <= w_we;
            r_io    <= w_io_hit;
            r_rdata <= '0;
            r_err   <= w_misalign;
            if (w_misalign) begin
              r_cpu_ack <= ~w_sel_ld;
              r_ld_ack  <= w_sel_ld;
              r_state   <= StResp;
            end else begin
              r_mem_en    <= ~w_io_hit;
              r_mem_we    <= ~w_io_hit & w_we;
              r_mem_addr  <= w_addr[ADDR_W+1:2];
              r_mem_wdata <= w_wdata;
              r_io_en     <= w_io_hit;
              r_io_we     <= w_io_hit & w_we;
              r_io_addr   <= w_addr[7:0];
              r_io_wdata  <= w_wdata;
              r_state     <= StIssue;
            end
          end
        end
        StIssue: begin
          r_mem_en    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_io_en     <= 1'b0;
          r_io_we     <= 1'b0;
          r_io_addr   <= '0;
          r_io_wdata  <= '0;
          if (!r_we && !r_io) begin
            r_state <= StWait;
          end else begin
            if (!r_we) r_rdata <= i_io_rdata;
            r_cpu_ack <= (r_gnt == GNT_CPU);
            r_ld_ack  <= (r_gnt == GNT_LOADER);
            r_state   <= StResp;
          end
        end
        StWait: begin
          r_rdata   <= i_mem_rdata;
          r_cpu_ack <= (r_gnt == GNT_CPU);
          r_ld_ack  <= (r_gnt == GNT_LOADER);
          r_state   <= StResp;
        end
        StResp: begin
          r_cpu_ack    <= 1'b0;
          r_ld_ack     <= 1'b0;
          r_err        <= 1'b0;
          r_last_grant <= r_gnt;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cpu_ack   = r_cpu_ack;
  assign o_ld_ack    = r_ld_ack;
  assign o_cpu_stall = i_cpu_req & ~r_cpu_ack;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_io_en     = r_io_en;
  assign o_io_we     = r_io_we;
  assign o_io_addr   = r_io_addr;
  assign o_io_wdata  = r_io_wdata;

endmodule
